// File: rtl/core_pkg.sv
// core_pkg: opcode constants, datapath select encodings and FSM states for the RV32I control path
package core_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
  typedef enum logic [1:0] {SRC_A_PC = 2'b00, SRC_A_OLD_PC = 2'b01, SRC_A_RS1 = 2'b10, SRC_A_ZERO = 2'b11} alu_src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALU_OUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_DEC = 2'b10} alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_EXEC_U, S_TRAP
  } state_t;

  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEM_ADR;
      OP_R:              return S_EXEC_R;
      OP_I:              return S_EXEC_I;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI, OP_AUIPC:  return S_EXEC_U;
      default:           return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/core_ctrl_fsm_branch_cond.sv
// branch_cond: resolves the branch condition from funct3 and the ALU flags
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       illegal
);
  // funct3 010/011 have no branch meaning and are never taken
  always_comb begin
    illegal = funct3[2:1] == 2'b01;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32I sequencer driving datapath selects and strobes; RESET_TRAP_CLR is reserved and must stay 1
module core_ctrl_fsm
  import core_pkg::*;
#(
  parameter bit RESET_TRAP_CLR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       imm_u,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       trap
);
  state_t state, state_nxt;
  logic taken, illegal;
  logic unused_funct7b5;

  assign unused_funct7b5 = funct7b5;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .taken  (taken),
    .illegal(illegal)
  );

  // state register; reset wins over every transition
  always_ff @(posedge clk)
    if (rst) state <= (RESET_TRAP_CLR || state != S_TRAP) ? S_FETCH : S_TRAP;
    else state <= state_nxt;

  // next state: memory states wait on mem_ready, DECODE dispatches on opcode
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:                      state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:                     state_nxt = decode_next(opcode);
      S_MEM_ADR:                    state_nxt = opcode == OP_STORE ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:                   state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE:                  state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_MEM_WB, S_ALU_WB:           state_nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_nxt = S_ALU_WB;
      S_BRANCH:                     state_nxt = illegal ? S_TRAP : S_FETCH;
      S_JAL:                        state_nxt = S_ALU_WB;
      S_JALR:                       state_nxt = S_JAL;
      default:                      state_nxt = S_TRAP;
    endcase
  end

  // Moore decode of state, forced to all-zero while rst is high; FETCH/BRANCH strobes also see mem_ready/taken
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    imm_u      = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALU_OUT;
    trap       = 1'b0;
    if (!rst)
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_src   = opcode == OP_BRANCH ? IMM_B : opcode == OP_JAL ? IMM_J : IMM_I;
        end
        S_MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_src   = opcode == OP_STORE ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_DEC;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_DEC;
        end
        S_EXEC_U: begin
          imm_u     = 1'b1;
          alu_src_a = opcode == OP_LUI ? SRC_A_ZERO : SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_ALU_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_SUB;
          pc_write  = taken;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: instruction-level reference model feeding a per-cycle expected-output scoreboard
module tb_core_ctrl_fsm;
  import core_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       imm_u;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] res;
    logic       trap;
  } out_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
  logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_u, trap;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;

  core_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src), .imm_u(imm_u),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .trap(trap)
  );

  always #5 clk = ~clk;

  out_t  exp_q[$];
  string tag_q[$];
  out_t  act, mon_e;
  string mon_t;
  int    vectors = 0, miscompares = 0;

  assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src, imm_u,
                alu_src_a, alu_src_b, alu_op, result_src, trap};

  // monitor: every DUT cycle presents a full output vector; compare it with the oldest expectation
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      vectors++;
      if (act !== mon_e) begin
        miscompares++;
        $display("FAIL %s @%0t: dut=%05h model=%05h", mon_t, $time, act, mon_e);
      end
    end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input out_t e, input string t, input logic mr);
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic mr);
    rst = 1'b1;
    repeat (n) cyc(out_t'(0), "reset", mr);
    rst = 1'b0;
  endtask

  task automatic fetch(input int w);
    out_t e;
    e = '0;
    e.mem_req = 1'b1;
    e.src_b = 2'd2;
    e.res = 2'd2;
    repeat (w) cyc(e, "fetch_wait", 1'b0);
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    cyc(e, "fetch", 1'b1);
  endtask

  task automatic decode(input logic [6:0] op);
    out_t e;
    e = '0;
    e.src_a = 2'd1;
    e.src_b = 2'd1;
    e.imm_src = op == OP_BRANCH ? 2'd2 : op == OP_JAL ? 2'd3 : 2'd0;
    cyc(e, "decode", rb());
  endtask

  task automatic mem_adr(input logic [6:0] op);
    out_t e;
    e = '0;
    e.src_a = 2'd2;
    e.src_b = 2'd1;
    e.imm_src = op == OP_STORE ? 2'd1 : 2'd0;
    cyc(e, "mem_adr", rb());
  endtask

  task automatic write_back(input string t);
    out_t e;
    e = '0;
    e.reg_write = 1'b1;
    cyc(e, t, rb());
  endtask

  task automatic trap_hold(input int n);
    out_t e;
    e = '0;
    e.trap = 1'b1;
    repeat (n) cyc(e, "trap_hold", rb());
  endtask

  // one whole instruction as the architecture describes it; trapped reports an illegal encoding
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic l,
                           input logic lu, input int fw, input int mw, output bit trapped);
    out_t e;
    logic cond;
    opcode = op;
    funct3 = f3;
    funct7b5 = rb();
    zero = z;
    lt = l;
    ltu = lu;
    trapped = 1'b0;
    fetch(fw);
    decode(op);
    e = '0;
    if (op == OP_LOAD || op == OP_STORE) begin
      mem_adr(op);
      e.mem_req = 1'b1;
      e.adr_src = 1'b1;
      e.mem_we = op == OP_STORE;
      repeat (mw) cyc(e, "mem_wait", 1'b0);
      cyc(e, "mem_done", 1'b1);
      if (op == OP_LOAD) begin
        e = '0;
        e.res = 2'd1;
        e.reg_write = 1'b1;
        cyc(e, "load_wb", rb());
      end
    end else if (op == OP_R || op == OP_I) begin
      e.src_a = 2'd2;
      e.src_b = op == OP_I ? 2'd1 : 2'd0;
      e.alu_op = 2'd2;
      cyc(e, "exec", rb());
      write_back("alu_wb");
    end else if (op == OP_LUI || op == OP_AUIPC) begin
      e.imm_u = 1'b1;
      e.src_a = op == OP_LUI ? 2'd3 : 2'd1;
      e.src_b = 2'd1;
      cyc(e, "exec_u", rb());
      write_back("u_wb");
    end else if (op == OP_BRANCH) begin
      cond = f3[2] ? (f3[1] ? lu : l) : z;
      trapped = f3[2:1] == 2'b01;
      e.src_a = 2'd2;
      e.alu_op = 2'd1;
      e.pc_write = !trapped && (cond ^ f3[0]);
      cyc(e, "branch", rb());
    end else if (op == OP_JAL || op == OP_JALR) begin
      if (op == OP_JALR) begin
        e.src_a = 2'd2;
        e.src_b = 2'd1;
        cyc(e, "jalr", rb());
        e = '0;
      end
      e.src_a = 2'd1;
      e.src_b = 2'd2;
      e.pc_write = 1'b1;
      cyc(e, "jal", rb());
      write_back("link_wb");
    end else trapped = 1'b1;
  endtask

  logic [6:0] ops[10] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7F};
  logic [6:0] bad_ops[4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};
  logic [6:0] op;
  bit tr;
  out_t ew;

  initial begin
    @(posedge clk);
    #1;
    do_reset(2, 1'b1);
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, tr);
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3, tr);
    run_instr(OP_BRANCH, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, tr);
    run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, 1, 0, tr);
    run_instr(OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 0, 0, tr);
    trap_hold(3);
    do_reset(1, 1'b1);
    run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, tr);
    trap_hold(20);
    do_reset(1, 1'b0);
    opcode = OP_STORE;
    fetch(0);
    decode(OP_STORE);
    mem_adr(OP_STORE);
    ew = '0;
    ew.mem_req = 1'b1;
    ew.mem_we = 1'b1;
    ew.adr_src = 1'b1;
    repeat (2) cyc(ew, "store_wait", 1'b0);
    do_reset(1, 1'b0);
    fetch(1);
    decode(OP_STORE);
    mem_adr(OP_STORE);
    cyc(ew, "store_done", 1'b1);
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 7'h7F) op = bad_ops[$urandom_range(0, 3)];
      run_instr(op, 3'($urandom_range(0, 7)), rb(), rb(), rb(),
                $urandom_range(0, 2), $urandom_range(0, 3), tr);
      if (tr) begin
        trap_hold($urandom_range(1, 5));
        do_reset($urandom_range(1, 2), rb());
      end
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: dut left %0d, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
